// File: rtl/dest_reg_writer.sv
// ---------------------------------------------------------------------------
// dest_reg_writer
//
// Write-back end of the B/C/D operand path. The operand mux reads one of
// B, C, D by a 2-bit select; this block writes one of them. A (select, data)
// request is taken on a valid/ready handshake, held for one cycle, and then
// committed into the addressed register. Select 2'b11 is illegal: the
// request is accepted, dropped, and flagged with a one-cycle error pulse.
//
// Handshake: a request transfers on a rising clk edge where wr_valid and
// wr_ready are both high. wr_ready depends only on the FSM state, never on
// wr_valid. The requester keeps wr_valid/wr_sel/wr_data stable until that
// edge; wr_sel/wr_data are ignored while wr_valid is low.
//
// Optional feature (macro WR_COUNT_EN):
//   defined   -> extra output wr_cnt[7:0], count of committed legal writes
//                (wraps 8'hFF -> 8'h00, cleared by reset, ERROR not counted)
//   undefined -> no wr_cnt port and no counter logic
//
// Ports:
//   clk        in   1       clock, all state changes on posedge
//   rst        in   1       synchronous active-high reset
//   wr_valid   in   1       request valid
//   wr_sel     in   2       destination: 00=B 01=C 10=D 11=illegal
//   wr_data    in   DATA_W  value to write
//   wr_ready   out  1       request can be accepted this cycle (IDLE)
//   reg_b/c/d  out  DATA_W  destination register contents
//   we_b/c/d   out  1       strobe in the cycle the register loads
//   wr_done    out  1       pulse: legal write committed this cycle
//   wr_err     out  1       pulse: illegal request dropped this cycle
//   wr_cnt     out  8       committed write count (WR_COUNT_EN only)
//   fsm_state  out  2       debug view of FSM: 0=IDLE 1=COMMIT 2=ERROR
// ---------------------------------------------------------------------------
module dest_reg_writer #(
    parameter int                 DATA_W    = 8,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [1:0]        wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [DATA_W-1:0] reg_b,
    output logic [DATA_W-1:0] reg_c,
    output logic [DATA_W-1:0] reg_d,
    output logic              we_b,
    output logic              we_c,
    output logic              we_d,
    output logic              wr_done,
    output logic              wr_err,
`ifdef WR_COUNT_EN
    output logic [7:0]        wr_cnt,
`endif
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COMMIT = 2'd1,
        S_ERROR  = 2'd2
    } state_t;

    localparam logic [1:0] SEL_B   = 2'b00;
    localparam logic [1:0] SEL_C   = 2'b01;
    localparam logic [1:0] SEL_D   = 2'b10;
    localparam logic [1:0] SEL_BAD = 2'b11;

    state_t              state_q;
    state_t              state_d;
    logic [1:0]          sel_q;
    logic [DATA_W-1:0]   data_q;
    logic                accept;

    assign accept    = wr_valid & wr_ready;
    assign fsm_state = state_q;

    // -----------------------------------------------------------------------
    // State register and holding registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                sel_q  <= wr_sel;
                data_q <= wr_data;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (wr_sel == SEL_BAD) ? S_ERROR : S_COMMIT;
                end
            end
            S_COMMIT: state_d = S_IDLE;
            S_ERROR:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs. Strobes and pulses are suppressed while rst is high so that a
    // write aborted by reset in COMMIT/ERROR never shows as completed.
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ready = 1'b0;
        we_b     = 1'b0;
        we_c     = 1'b0;
        we_d     = 1'b0;
        wr_done  = 1'b0;
        wr_err   = 1'b0;
        case (state_q)
            S_IDLE: begin
                wr_ready = 1'b1;
            end
            S_COMMIT: begin
                if (!rst) begin
                    wr_done = 1'b1;
                    case (sel_q)
                        SEL_B:   we_b = 1'b1;
                        SEL_C:   we_c = 1'b1;
                        SEL_D:   we_d = 1'b1;
                        default: ;  // 11 always routes to ERROR, never here
                    endcase
                end
            end
            S_ERROR: begin
                if (!rst) begin
                    wr_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Destination registers: each loads held data on the edge ending the
    // cycle its strobe is high.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_b <= RESET_VAL;
            reg_c <= RESET_VAL;
            reg_d <= RESET_VAL;
        end else begin
            if (we_b) reg_b <= data_q;
            if (we_c) reg_c <= data_q;
            if (we_d) reg_d <= data_q;
        end
    end

`ifdef WR_COUNT_EN
    // Counts committed legal writes; becomes visible the cycle after wr_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt <= 8'h00;
        end else if (wr_done) begin
            wr_cnt <= wr_cnt + 8'h01;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Invariants
    // -----------------------------------------------------------------------
    a_done_err_exclusive : assert property (@(posedge clk) disable iff (rst)
        !(wr_done && wr_err));
    a_strobe_onehot : assert property (@(posedge clk) disable iff (rst)
        $onehot0({we_b, we_c, we_d}));
    a_commit_one_cycle : assert property (@(posedge clk) disable iff (rst)
        (state_q != S_IDLE) |=> (state_q == S_IDLE));

endmodule
